// File: rtl/hazard_pkg.sv
// ============================================================================
//  Module      : hazard_pkg
//  Description : Shared types and constants for the pipeline hazard
//                controller: forwarding-select encoding, the load result
//                source code, the per-stage destination record and the
//                forwarding-priority helper.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package hazard_pkg;

    // Register address width carried inside a stage record. The top-level
    // REG_ADDR_W parameter must match this value.
    localparam int REC_ADDR_W = 5;

    // result_src encoding that marks a load (data arrives from memory late)
    localparam logic [1:0] RESULT_SRC_LOAD = 2'b01;

    // EX-stage operand forwarding mux select; 2'b11 is never generated
    typedef enum logic [1:0] {
        FWD_RF  = 2'b00,
        FWD_WB  = 2'b01,
        FWD_MEM = 2'b10
    } fwd_sel_t;

    // Per-stage record; the all-zero value is a bubble
    typedef struct packed {
        logic [REC_ADDR_W-1:0] rs1;
        logic [REC_ADDR_W-1:0] rs2;
        logic [REC_ADDR_W-1:0] rd;
        logic                  reg_write;
        logic [1:0]            result_src;
    } stage_rec_t;

    // Select the forwarding source for one EX operand. The younger MEM
    // producer overrides WB; writes to x0 are never forwarded.
    function automatic fwd_sel_t fwd_select(
        input logic [REC_ADDR_W-1:0] rs,
        input logic [REC_ADDR_W-1:0] m_rd,
        input logic                  m_we,
        input logic [REC_ADDR_W-1:0] w_rd,
        input logic                  w_we
    );
        fwd_sel_t sel;
        sel = FWD_RF;
        if (w_we && (w_rd != '0) && (w_rd == rs)) begin
            sel = FWD_WB;
        end
        if (m_we && (m_rd != '0) && (m_rd == rs)) begin
            sel = FWD_MEM;
        end
        return sel;
    endfunction

endpackage

`default_nettype wire

// File: rtl/hazard_stage_reg.sv
// ============================================================================
//  Module      : hazard_stage_reg
//  Description : One pipeline-stage record register. Asynchronous active-high
//                reset and a synchronous clear, both of which load a bubble.
//  Ports       : clk      - core clock
//                reset    - asynchronous active-high reset
//                i_clear  - load a bubble on the next clock edge
//                i_rec    - record from the previous stage
//                o_rec    - registered record for this stage
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module hazard_stage_reg
    import hazard_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       i_clear,
    input  stage_rec_t i_rec,
    output stage_rec_t o_rec
);

    stage_rec_t r_rec;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rec <= '0;
        end else if (i_clear) begin
            r_rec <= '0;
        end else begin
            r_rec <= i_rec;
        end
    end

    assign o_rec = r_rec;

endmodule

`default_nettype wire

// File: rtl/hazard_ctrl.sv
// ============================================================================
//  Module      : hazard_ctrl
//  Description : Pipeline hazard controller for a 5-stage core. Tracks the
//                E/M/W destination records in step with the datapath and
//                produces EX-stage forwarding selects, load-use stalls and
//                branch flushes. All outputs are combinational from the
//                internal records and the current Decode/branch inputs.
//  Ports       : clk, reset               - clock, async active-high reset
//                rs1_d, rs2_d, rd_d       - Decode register fields
//                reg_write_d              - Decode instruction writes RF
//                result_src_d             - Decode result source (01 = load)
//                pc_src_e                 - taken branch/jump resolved in EX
//                forward_a_e, forward_b_e - EX operand forwarding selects
//                stall_f, stall_d         - hold PC / F-D register
//                flush_d, flush_e         - clear F-D / D-E register
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int REG_ADDR_W = 5
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [REG_ADDR_W-1:0] rs1_d,
    input  logic [REG_ADDR_W-1:0] rs2_d,
    input  logic [REG_ADDR_W-1:0] rd_d,
    input  logic                  reg_write_d,
    input  logic [1:0]            result_src_d,
    input  logic                  pc_src_e,
    output logic [1:0]            forward_a_e,
    output logic [1:0]            forward_b_e,
    output logic                  stall_f,
    output logic                  stall_d,
    output logic                  flush_d,
    output logic                  flush_e
);

    stage_rec_t w_rec_d;
    stage_rec_t w_rec_e;
    stage_rec_t w_rec_m;
    stage_rec_t w_rec_w;
    logic       w_lw_stall;
    logic       w_flush_e;
    fwd_sel_t   w_fwd_a;
    fwd_sel_t   w_fwd_b;

    assign w_rec_d = '{rs1:        rs1_d,
                       rs2:        rs2_d,
                       rd:         rd_d,
                       reg_write:  reg_write_d,
                       result_src: result_src_d};

    // E is bubbled on flush; M and W never stall or clear, they just follow.
    hazard_stage_reg u_stage_e (
        .clk     (clk),
        .reset   (reset),
        .i_clear (w_flush_e),
        .i_rec   (w_rec_d),
        .o_rec   (w_rec_e)
    );

    hazard_stage_reg u_stage_m (
        .clk     (clk),
        .reset   (reset),
        .i_clear (1'b0),
        .i_rec   (w_rec_e),
        .o_rec   (w_rec_m)
    );

    hazard_stage_reg u_stage_w (
        .clk     (clk),
        .reset   (reset),
        .i_clear (1'b0),
        .i_rec   (w_rec_m),
        .o_rec   (w_rec_w)
    );

    // Only destination info of the WB record is consumed.
    logic w_unused_w_fields;
    assign w_unused_w_fields = ^{w_rec_w.rs1, w_rec_w.rs2, w_rec_w.result_src};

    assign w_fwd_a = fwd_select(w_rec_e.rs1, w_rec_m.rd, w_rec_m.reg_write,
                                w_rec_w.rd, w_rec_w.reg_write);
    assign w_fwd_b = fwd_select(w_rec_e.rs2, w_rec_m.rd, w_rec_m.reg_write,
                                w_rec_w.rd, w_rec_w.reg_write);

    // A load in E whose data the Decode instruction needs: hold F/D one
    // cycle and bubble E. Load data is then forwarded from WB.
    assign w_lw_stall = (w_rec_e.result_src == RESULT_SRC_LOAD) &&
                        (w_rec_e.rd != '0) &&
                        ((w_rec_e.rd == rs1_d) || (w_rec_e.rd == rs2_d));

    assign w_flush_e = w_lw_stall | pc_src_e;

    assign forward_a_e = w_fwd_a;
    assign forward_b_e = w_fwd_b;
    // A taken branch kills the Decode instruction, so stalling it is moot.
    assign stall_f     = w_lw_stall & ~pc_src_e;
    assign stall_d     = w_lw_stall & ~pc_src_e;
    assign flush_d     = pc_src_e;
    assign flush_e     = w_flush_e;

endmodule

`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
// ============================================================================
//  Module      : tb_hazard_ctrl
//  Description : Self-checking bench for hazard_ctrl: directed scenarios and
//                randomized stimulus against a history-based reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_hazard_ctrl;

    logic       clk;
    logic       reset;
    logic [4:0] rs1_d, rs2_d, rd_d;
    logic       reg_write_d;
    logic [1:0] result_src_d;
    logic       pc_src_e;
    logic [1:0] forward_a_e, forward_b_e;
    logic       stall_f, stall_d, flush_d, flush_e;

    hazard_ctrl #(.REG_ADDR_W(5)) dut (
        .clk          (clk),
        .reset        (reset),
        .rs1_d        (rs1_d),
        .rs2_d        (rs2_d),
        .rd_d         (rd_d),
        .reg_write_d  (reg_write_d),
        .result_src_d (result_src_d),
        .pc_src_e     (pc_src_e),
        .forward_a_e  (forward_a_e),
        .forward_b_e  (forward_b_e),
        .stall_f      (stall_f),
        .stall_d      (stall_d),
        .flush_d      (flush_d),
        .flush_e      (flush_e)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input int obs, input int exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference model: history of instructions that entered EX, newest first.
    // hist[0] is in EX, hist[1] one stage older (MEM), hist[2] in WB.
    typedef struct {
        int rs1;
        int rs2;
        int rd;
        bit wr;
        bit load;
    } ins_t;

    ins_t hist[$];

    function automatic ins_t bubble();
        ins_t b;
        b.rs1 = 0; b.rs2 = 0; b.rd = 0; b.wr = 0; b.load = 0;
        return b;
    endfunction

    task automatic model_clear();
        hist.delete();
        for (int i = 0; i < 3; i++) hist.push_back(bubble());
    endtask

    // Youngest older producer wins: MEM -> 2, WB -> 1, else register file.
    function automatic int exp_fwd(input int rs);
        for (int age = 1; age <= 2; age++) begin
            if (hist[age].wr && hist[age].rd != 0 && hist[age].rd == rs)
                return (age == 1) ? 2 : 1;
        end
        return 0;
    endfunction

    function automatic bit exp_lw(input int a, input int b);
        return hist[0].load && hist[0].rd != 0 && (hist[0].rd == a || hist[0].rd == b);
    endfunction

    int s_fa, s_fb, s_sf, s_sd, s_fd, s_fe;

    // One clock cycle: drive Decode inputs, check at negedge, advance model.
    task automatic drive(input int rs1, input int rs2, input int rd, input bit wr,
                         input int rsrc, input bit br);
        bit   lw, fl;
        ins_t n;
        rs1_d = 5'(rs1); rs2_d = 5'(rs2); rd_d = 5'(rd);
        reg_write_d = wr; result_src_d = 2'(rsrc); pc_src_e = br;
        @(negedge clk);
        s_fa = forward_a_e; s_fb = forward_b_e;
        s_sf = stall_f; s_sd = stall_d; s_fd = flush_d; s_fe = flush_e;
        lw = exp_lw(rs1, rs2);
        fl = lw || br;
        check("fwd_a",   s_fa, exp_fwd(hist[0].rs1));
        check("fwd_b",   s_fb, exp_fwd(hist[0].rs2));
        check("stall_f", s_sf, int'(lw && !br));
        check("stall_d", s_sd, int'(lw && !br));
        check("flush_d", s_fd, int'(br));
        check("flush_e", s_fe, int'(fl));
        @(posedge clk);
        if (fl) n = bubble();
        else begin
            n.rs1 = rs1; n.rs2 = rs2; n.rd = rd; n.wr = wr; n.load = (rsrc == 1);
        end
        hist.push_front(n);
        void'(hist.pop_back());
        #1;
    endtask

    task automatic nop();
        drive(0, 0, 0, 0, 0, 0);
    endtask

    // Reset asserted between edges with garbage on Decode inputs.
    task automatic do_reset();
        rs1_d = 5'($urandom); rs2_d = 5'($urandom); rd_d = 5'($urandom);
        reg_write_d = 1'($urandom); result_src_d = 2'($urandom); pc_src_e = 1'b0;
        reset = 1'b1;
        #1;
        check("rst_fwd_a",   forward_a_e, 0);
        check("rst_fwd_b",   forward_b_e, 0);
        check("rst_stall_f", stall_f, 0);
        check("rst_stall_d", stall_d, 0);
        check("rst_flush_d", flush_d, 0);
        check("rst_flush_e", flush_e, 0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        model_clear();
    endtask

    initial begin
        reset = 1'b1;
        rs1_d = '0; rs2_d = '0; rd_d = '0; reg_write_d = 1'b0;
        result_src_d = '0; pc_src_e = 1'b0;
        model_clear();
        @(posedge clk);
        #1;
        do_reset();

        // First cycles after reset with no writers: register file only
        for (int i = 0; i < 3; i++) begin
            drive(int'($urandom_range(0, 31)), int'($urandom_range(0, 31)),
                  int'($urandom_range(0, 31)), 0, 0, 0);
            check("post_rst_fwd_a", s_fa, 0);
        end

        // MEM forward on A and B
        drive(0, 0, 5, 1, 0, 0); drive(5, 0, 0, 0, 0, 0); nop();
        check("mem_fwd_a", s_fa, 2);
        drive(0, 0, 5, 1, 0, 0); drive(0, 5, 0, 0, 0, 0); nop();
        check("mem_fwd_b", s_fb, 2);

        // Two writers to x6: MEM beats WB
        drive(0, 0, 6, 1, 0, 0); drive(0, 0, 6, 1, 0, 0);
        drive(6, 0, 0, 0, 0, 0); nop();
        check("mem_prio", s_fa, 2);

        // Single writer with one gap: WB forward
        drive(0, 0, 9, 1, 0, 0); nop(); drive(9, 0, 0, 0, 0, 0); nop();
        check("wb_fwd_a", s_fa, 1);

        // x0 never forwards, load to x0 never stalls
        drive(0, 0, 0, 1, 0, 0); drive(0, 0, 0, 0, 0, 0); nop();
        check("x0_fwd", s_fa, 0);
        drive(0, 0, 0, 1, 1, 0); drive(0, 0, 0, 0, 0, 0);
        check("x0_no_stall", s_sf, 0);
        nop(); nop();

        // Load-use: one stall cycle, then WB forward to B
        drive(0, 0, 7, 1, 1, 0);
        drive(0, 7, 0, 0, 0, 0);
        check("lu_stall_f", s_sf, 1);
        check("lu_stall_d", s_sd, 1);
        check("lu_flush_e", s_fe, 1);
        drive(0, 7, 0, 0, 0, 0);
        check("lu_one_cycle", s_sf, 0);
        nop();
        check("lu_wb_fwd_b", s_fb, 1);

        // Load-use and branch together: branch wins
        drive(0, 0, 8, 1, 1, 0);
        drive(8, 8, 0, 0, 0, 1);
        check("br_flush_d", s_fd, 1);
        check("br_flush_e", s_fe, 1);
        check("br_stall_f", s_sf, 0);
        check("br_stall_d", s_sd, 0);
        nop();
        check("br_bubble_a", s_fa, 0);
        check("br_bubble_b", s_fb, 0);

        // Randomized traffic on a small register set to provoke hazards
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 199) == 0) do_reset();
            drive(int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
                  int'($urandom_range(0, 7)), 1'($urandom_range(0, 3) != 0),
                  int'($urandom_range(0, 3)), $urandom_range(0, 7) == 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard controller driving the select inputs of the EX-stage 3:1 operand forwarding muxes, plus stall/flush controls for the F/D/E pipeline registers. Decode-stage register fields enter the block, which carries its own EX/MEM/WB scoreboard of destination info in step with the datapath. The block produces forwarding codes, load-use stalls and branch flushes from that scoreboard. It sits beside the datapath in the 5-stage core, the control-side counterpart of the forwarding muxes.

## Interface
- Parameters:
- REG_ADDR_W, 5, register-file address width
- Ports:
- clk  in  1  core clock
- reset  in  1  asynchronous, active-high; clears all internal stage state
- rs1_d  in  REG_ADDR_W  source register 1 of instruction in Decode
- rs2_d  in  REG_ADDR_W  source register 2 of instruction in Decode
- rd_d  in  REG_ADDR_W  destination register of instruction in Decode
- reg_write_d  in  1  Decode instruction writes the register file
- result_src_d  in  2  result source of the Decode instruction; 2'b01 = load
- pc_src_e  in  1  taken branch/jump resolved in EX this cycle
- forward_a_e  out  2  select for the SrcA forwarding mux
- forward_b_e  out  2  select for the SrcB forwarding mux
- stall_f  out  1  hold the PC register
- stall_d  out  1  hold the F/D register
- flush_d  out  1  clear the F/D register
- flush_e  out  1  clear the D/E register

## Operation
- Internal stage records E, M, W each hold {rs1, rs2, rd, reg_write, result_src}. M and W use only rd/reg_write. A bubble is the all-zero record.
- Shift on every clk edge:
  - E <= bubble if flush_e, else D fields.
  - M <= E.
  - W <= M.
- The M and W records never stall. Stalling only holds F/D upstream.
- Forwarding codes:
  - 2'b10 (MEM ALU result) if M.reg_write, M.rd != 0 and M.rd == E.rs1.
  - Else 2'b01 (WB result) if W.reg_write, W.rd != 0 and W.rd == E.rs1.
  - Else 2'b00 (register file).
  - MEM has priority over WB.
  - forward_b_e uses the same rule with E.rs2.
  - 2'b11 is never produced.
- Load-use:
  - lw_stall = (E.result_src == 2'b01) & (E.rd != 0) & (E.rd == rs1_d | E.rd == rs2_d).
  - A load into x0 never stalls.
- Branch: pc_src_e asserts flush_d and flush_e.
- Output equations:
  - stall_f = stall_d = lw_stall & ~pc_src_e. A branch takes precedence: a wrong-path instruction is never stalled.
  - flush_e = lw_stall | pc_src_e.
  - flush_d = pc_src_e.

## Timing
- Reset values: all internal records are bubbles. forward_a_e = forward_b_e = 2'b00, and stall_f, stall_d, flush_d, flush_e are all 0 (given pc_src_e = 0 and the E record empty).
- All outputs are combinational from the internal records and current inputs. There are no output registers, so the value is valid in the same cycle.
- An instruction presented on the *_d inputs in cycle n:
  - is in E at n+1, M at n+2 and W at n+3, unless flushed;
  - is forwarded from MEM at n+2 and from WB at n+3 to a dependent in E.
- Load-use: one bubble. In cycle n the load is in E and the dependent in D, and the block stalls F/D and flushes E. At n+1 the load is in M and the dependent is still in D (no stall). At n+2 the dependent reaches E and gets 2'b01 from WB.
- A stall lasts exactly one cycle per load, since the bubble clears E.result_src.
- Simultaneous load-use and branch: flush_d = flush_e = 1 and stall_f = stall_d = 0.
- Reset asserted mid-operation immediately clears all records. In-flight state is discarded and outputs return to reset values asynchronously.

## Structure
- Shared package hazard_pkg holds:
  - typedef fwd_sel_t: FWD_RF = 2'b00, FWD_WB = 2'b01, FWD_MEM = 2'b10;
  - constant RESULT_SRC_LOAD = 2'b01;
  - typedef stage_rec_t for the record struct.
- One sub-module is natural: hazard_stage_reg, an async-reset record register with a synchronous clear (bubble) input, instantiated three times.

## Test plan
- Reset: assert reset with garbage on the inputs. All outputs are 0, and forward_a_e = 2'b00 for the first 3 cycles after release with reg_write_d = 0.
- MEM forward: cycle 0 rd_d = 5 with reg_write_d = 1, cycle 1 rs1_d = 5. At cycle 2 forward_a_e = 2'b10. Repeat with rs2_d for forward_b_e.
- WB forward and priority:
  - Writes to x6 in cycles 0 and 1, reader rs1_d = 6 in cycle 2. At cycle 3 forward_a_e = 2'b10 (MEM wins).
  - Single writer with one gap instruction gives 2'b01.
- x0: writer rd_d = 0, then reader rs1_d = 0. forward_a_e stays 2'b00. A load to x0 followed by a reader of x0 gives no stall.
- Load-use: load rd_d = 7 (result_src_d = 2'b01), next rs2_d = 7.
  - One cycle of stall_f = stall_d = flush_e = 1.
  - Then two cycles later forward_b_e = 2'b01.
- Branch vs. load-use: create a load-use condition with pc_src_e = 1 in the same cycle. flush_d = flush_e = 1, stall_f = stall_d = 0. The following cycle's E record is a bubble, so forward_a_e = forward_b_e = 2'b00.
